// File: rtl/stream_width_divider_if.sv
// AXI4-Stream bundle used on both sides of the width divider.
// DATA_W sets tdata width; tkeep carries one bit per byte.
interface stream_width_divider_if #(
  parameter int DATA_W = 64
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/stream_width_divider.sv
// Wide-to-narrow AXI4-Stream converter. Each accepted word is held in a
// single buffer and emitted lane by lane (lane 0 first). On the final lane
// the buffer reloads in the same cycle, so back-to-back words produce no
// bubbles. Unused trailing lanes of a packet's last word are skipped, and
// malformed tkeep patterns raise a one-cycle error pulse.
module stream_width_divider #(
  parameter int DIVIDE_VALUE = 4,
  parameter int OUTPUT_WIDTH = 64
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  stream_width_divider_if.slave  s_axis,
  stream_width_divider_if.master m_axis,
  output logic                   error
);

  localparam int IN_WIDTH  = DIVIDE_VALUE * OUTPUT_WIDTH;
  localparam int LANE_KEEP = OUTPUT_WIDTH / 8;
  localparam int IN_KEEP   = IN_WIDTH / 8;
  localparam int LANE_W    = (DIVIDE_VALUE > 1) ? $clog2(DIVIDE_VALUE) : 1;
  localparam logic [LANE_W-1:0] MAX_LANE = LANE_W'(DIVIDE_VALUE - 1);

  // Holding buffer and lane sequencing state
  logic [IN_WIDTH-1:0] data_reg;
  logic [IN_KEEP-1:0]  keep_reg;
  logic                user_reg;
  logic                last_reg;
  logic                buf_valid_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [LANE_W-1:0]   last_lane_reg;
  logic                error_reg;

  // Per-lane views of the input mask and of the buffer
  logic [DIVIDE_VALUE-1:0] in_lane_any;
  logic [OUTPUT_WIDTH-1:0] data_lanes [DIVIDE_VALUE];
  logic [LANE_KEEP-1:0]    keep_lanes [DIVIDE_VALUE];

  logic [LANE_W-1:0]  in_last_lane;
  logic [IN_KEEP-1:0] keep_plus_one;
  logic               keep_full;
  logic               keep_contig;
  logic               in_malformed;
  logic               at_final;
  logic               s_ready;
  logic               s_hs;
  logic               m_hs;

  genvar gi;
  generate
    for (gi = 0; gi < DIVIDE_VALUE; gi++) begin : g_lane
      assign in_lane_any[gi] = |s_axis.tkeep[gi*LANE_KEEP +: LANE_KEEP];
      assign data_lanes[gi]  = data_reg[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      assign keep_lanes[gi]  = keep_reg[gi*LANE_KEEP +: LANE_KEEP];
    end
  endgenerate

  // Final lane of the incoming word: full width unless it ends a packet,
  // in which case it is the highest lane carrying any byte (0 if none)
  always_comb begin
    in_last_lane = MAX_LANE;
    if (s_axis.tlast) begin
      in_last_lane = '0;
      for (int k = 0; k < DIVIDE_VALUE; k++) begin
        if (in_lane_any[k]) begin
          in_last_lane = LANE_W'(k);
        end
      end
    end
  end

  // A mask is contiguous from bit 0 when adding one clears every set bit;
  // an all-zero last word is treated as malformed as well
  assign keep_plus_one = s_axis.tkeep + IN_KEEP'(1);
  assign keep_full     = &s_axis.tkeep;
  assign keep_contig   = (s_axis.tkeep != '0) && ((s_axis.tkeep & keep_plus_one) == '0);
  assign in_malformed  = s_axis.tlast ? !keep_contig : !keep_full;

  assign at_final = (lane_reg == last_lane_reg);
  assign s_ready  = axi_resetn && (!buf_valid_reg || (m_axis.tready && at_final));
  assign s_hs     = s_axis.tvalid && s_ready;
  assign m_hs     = buf_valid_reg && m_axis.tready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = buf_valid_reg;
  assign m_axis.tdata  = data_lanes[lane_reg];
  assign m_axis.tkeep  = keep_lanes[lane_reg];
  assign m_axis.tuser  = user_reg;
  assign m_axis.tlast  = last_reg && at_final;
  assign error         = error_reg;

  // Advance lanes on output handshakes and (re)load the buffer on input handshakes
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      data_reg      <= '0;
      keep_reg      <= '0;
      user_reg      <= 1'b0;
      last_reg      <= 1'b0;
      buf_valid_reg <= 1'b0;
      lane_reg      <= '0;
      last_lane_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      error_reg <= s_hs && in_malformed;
      if (m_hs) begin
        if (!at_final) begin
          lane_reg <= lane_reg + LANE_W'(1);
        end else begin
          lane_reg <= '0;
          if (!s_hs) begin
            buf_valid_reg <= 1'b0;
          end
        end
      end
      if (s_hs) begin
        data_reg      <= s_axis.tdata;
        keep_reg      <= s_axis.tkeep;
        user_reg      <= s_axis.tuser;
        last_reg      <= s_axis.tlast;
        last_lane_reg <= in_last_lane;
        buf_valid_reg <= 1'b1;
        lane_reg      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_width_divider.sv
// Directed bench for stream_width_divider: a driver pushes expected beats
// into a scoreboard queue when it issues a word; an independent monitor
// pops and compares on every output handshake and checks error pulses.
module tb_stream_width_divider;

  localparam int DV = 4;
  localparam int OW = 64;
  localparam int IW = DV * OW;

  typedef struct packed {
    logic [OW-1:0]   data;
    logic [OW/8-1:0] keep;
    logic            user;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic error;

  stream_width_divider_if #(.DATA_W(IW)) s_if ();
  stream_width_divider_if #(.DATA_W(OW)) m_if ();

  stream_width_divider #(.DIVIDE_VALUE(DV), .OUTPUT_WIDTH(OW)) dut (
    .axi_aclk  (clk),
    .axi_resetn(rst_n),
    .s_axis    (s_if.slave),
    .m_axis    (m_if.master),
    .error     (error)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    hs_count = 0;
  int    first_hs = 0;
  int    last_hs = 0;
  logic  drv_err = 1'b0;
  logic  err_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [IW-1:0] mk_data(input logic [7:0] base);
    logic [IW-1:0] d;
    for (int i = 0; i < IW / 8; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  // Output ready: always high, or the repeating 1,0,0,1 pattern
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) m_if.tready = 1'b1;
      else m_if.tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  // Monitor: error pulse, hold stability under back-pressure, scoreboard pops
  initial begin
    beat_t cur, held_beat, e;
    logic  held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        err_pending = 1'b0;
        continue;
      end
      check("error_pulse", 128'(error), 128'(err_pending));
      err_pending = s_if.tvalid && s_if.tready && drv_err;
      cur.data = m_if.tdata;
      cur.keep = m_if.tkeep;
      cur.user = m_if.tuser;
      cur.last = m_if.tlast;
      if (held) check("hold_stable", 128'({m_if.tvalid, cur}), 128'({1'b1, held_beat}));
      held = 1'b0;
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat actual=%0h required=%0h", cur, e);
          end
        end
        hs_count++;
        if (hs_count == 1) first_hs = cyc;
        last_hs = cyc;
      end else if (m_if.tvalid) begin
        held = 1'b1;
        held_beat = cur;
      end
    end
  end

  // Issue one word; nb and e are the hand-computed beat count and error flag
  task automatic send_word(input logic [IW-1:0] d, input logic [IW/8-1:0] k,
                           input logic l, input logic u, input int nb, input logic e);
    beat_t b;
    logic  ok;
    for (int i = 0; i < nb; i++) begin
      b.data = d[i*OW +: OW];
      b.keep = k[i*(OW/8) +: (OW/8)];
      b.user = u;
      b.last = l && (i == nb - 1);
      exp_q.push_back(b);
    end
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    drv_err     = e;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_if.tready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (2) @(negedge clk);
    check(name, 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet3();
    send_word(mk_data(8'h20), 32'hFFFFFFFF, 1'b0, 1'b1, 4, 1'b0);
    send_word(mk_data(8'h40), 32'hFFFFFFFF, 1'b0, 1'b0, 4, 1'b0);
    send_word(mk_data(8'h60), 32'h000003FF, 1'b1, 1'b1, 2, 1'b0);
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tvalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tvalid", 128'(m_if.tvalid), 128'(0));
    check("reset_tdata",  128'(m_if.tdata),  128'(0));
    check("reset_tkeep",  128'(m_if.tkeep),  128'(0));
    check("reset_tlast",  128'(m_if.tlast),  128'(0));
    check("reset_tuser",  128'(m_if.tuser),  128'(0));
    check("reset_tready", 128'(s_if.tready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_reset", 128'(s_if.tready), 128'(1));
    @(posedge clk);
    #1;

    // Single full last word: 4 beats, s_axis_tready low for 3 cycles
    send_word(mk_data(8'h00), 32'hFFFFFFFF, 1'b1, 1'b0, 4, 1'b0);
    @(negedge clk);
    check("first_beat_tdata", 128'(m_if.tdata), 128'(64'h0706050403020100));
    check("first_beat_tkeep", 128'(m_if.tkeep), 128'(8'hFF));
    check("busy_tready0", 128'(s_if.tready), 128'(0));
    @(negedge clk);
    check("busy_tready1", 128'(s_if.tready), 128'(0));
    @(negedge clk);
    check("busy_tready2", 128'(s_if.tready), 128'(0));
    @(negedge clk);
    check("busy_tready3", 128'(s_if.tready), 128'(1));
    drain("drain_single");

    // Three-word packet, ready held high: 10 beats with no bubble
    hs_count = 0;
    send_packet3();
    drain("drain_packet");
    check("packet_beats", 128'(hs_count), 128'(10));
    check("packet_no_bubble", 128'(last_hs - first_hs), 128'(9));

    // Same packet under 1,0,0,1 back-pressure
    hs_count = 0;
    ready_mode = 1;
    send_packet3();
    drain("drain_backpressure");
    check("backpressure_beats", 128'(hs_count), 128'(10));
    ready_mode = 0;

    // Malformed words
    send_word(mk_data(8'h80), 32'hFFFFFF00, 1'b0, 1'b1, 4, 1'b1);
    send_word(mk_data(8'hA0), 32'h00000000, 1'b1, 1'b0, 1, 1'b1);
    send_word(mk_data(8'hC0), 32'h0000F0FF, 1'b1, 1'b1, 2, 1'b1);
    drain("drain_malformed");

    // Reset during beat 2 of a 4-beat word
    send_word(mk_data(8'hE0), 32'hFFFFFFFF, 1'b0, 1'b0, 4, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_tvalid", 128'(m_if.tvalid), 128'(1));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midreset_tvalid", 128'(m_if.tvalid), 128'(0));
    check("midreset_tready", 128'(s_if.tready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tready", 128'(s_if.tready), 128'(1));
    check("post_reset_tvalid", 128'(m_if.tvalid), 128'(0));
    @(posedge clk);
    #1;
    send_word(mk_data(8'h10), 32'hFFFFFFFF, 1'b1, 1'b1, 4, 1'b0);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
